// File: rtl/addsub_seq_pkg.sv
// Shared types and constants for the nibble-serial add/subtract controller.
package addsub_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  // Nibble-index width; never narrower than one bit.
  function automatic int idx_w(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/addsub_seq_ctrl_adder.sv
// Classic 4-bit adder/subtractor: mode=1 inverts B and injects a carry-in of 1.
module AdderSubtractor4Bit
  import addsub_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_a,
  input  logic [NIBBLE_W-1:0] i_b,
  input  logic                i_mode,
  output logic [NIBBLE_W-1:0] o_sum,
  output logic                o_carry
);

  logic [NIBBLE_W-1:0] w_b;

  assign w_b = i_b ^ {NIBBLE_W{i_mode}};
  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, w_b} + {{NIBBLE_W{1'b0}}, i_mode};

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Wide add/subtract sequenced one nibble per cycle through a single shared
// 4-bit adder/subtractor, with valid/ready request and response channels.
module addsub_seq_ctrl
  import addsub_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] req_a,
  input  logic [NIBBLE_W*NIBBLES-1:0] req_b,
  input  logic                        req_mode,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] rsp_result,
  output logic                        rsp_carry,
  output logic                        rsp_ovf,
  output logic                        rsp_zero
);

  localparam int W    = NIBBLE_W * NIBBLES;
  localparam int IDXW = idx_w(NIBBLES);
  localparam int BW   = IDXW + 2;
  localparam logic [IDXW-1:0] LAST = IDXW'(NIBBLES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [W-1:0]        r_a;
  logic [W-1:0]        r_b;
  logic                r_mode;
  logic                r_c;
  logic [IDXW-1:0]     r_idx;
  logic [W-1:0]        r_result;
  logic                r_carry;
  logic                r_ovf;
  logic                r_zero;

  logic [BW-1:0]       w_base;
  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_beff;
  logic [NIBBLE_W-1:0] w_unit_b;
  logic [NIBBLE_W-1:0] w_sum;
  logic                w_cout;
  logic                w_last;
  logic [W-1:0]        w_res_nxt;

  assign w_base  = BW'(r_idx) * BW'(NIBBLE_W);
  assign w_a_nib = r_a[w_base +: NIBBLE_W];
  assign w_beff  = r_mode ? ~r_b[w_base +: NIBBLE_W] : r_b[w_base +: NIBBLE_W];
  assign w_last  = (r_idx == LAST);

  // Pre-flipping B by the running carry makes the unit's own mode-driven
  // inversion cancel out, leaving A + Beff + c with the carry as carry-in.
  assign w_unit_b = w_beff ^ {NIBBLE_W{r_c}};

  AdderSubtractor4Bit u_nibble_alu (
    .i_a    (w_a_nib),
    .i_b    (w_unit_b),
    .i_mode (r_c),
    .o_sum  (w_sum),
    .o_carry(w_cout)
  );

  always_comb begin
    w_res_nxt                      = r_result;
    w_res_nxt[w_base +: NIBBLE_W]  = w_sum;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = CALC;
      end
      CALC: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_mode   <= 1'b0;
      r_c      <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_a      <= req_a;
            r_b      <= req_b;
            r_mode   <= req_mode;
            r_c      <= req_mode;
            r_idx    <= '0;
            r_result <= '0;
          end
        end
        CALC: begin
          r_result <= w_res_nxt;
          r_c      <= w_cout;
          r_idx    <= w_last ? '0 : r_idx + 1'b1;
          if (w_last) begin
            r_carry <= w_cout;
            r_ovf   <= (w_a_nib[NIBBLE_W-1] == w_beff[NIBBLE_W-1]) &&
                       (w_sum[NIBBLE_W-1] != w_a_nib[NIBBLE_W-1]);
            r_zero  <= (w_res_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_result = r_result;
  assign rsp_carry  = r_carry;
  assign rsp_ovf    = r_ovf;
  assign rsp_zero   = r_zero;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Bench for addsub_seq_ctrl: directed corner cases plus a random regression
// on a 4-nibble and a 2-nibble instance against an arithmetic reference.
module tb_addsub_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;
  logic        tb_vld, tb_rdy;
  logic [15:0] a, b;
  logic        m;

  logic        rr4, rv4, c4, v4, z4;
  logic [15:0] res4;
  logic        rr2, rv2, c2, v2, z2;
  logic [7:0]  res2;

  addsub_seq_ctrl #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(tb_vld & ~sel), .req_ready(rr4),
    .req_a(a), .req_b(b), .req_mode(m),
    .rsp_valid(rv4), .rsp_ready(tb_rdy & ~sel),
    .rsp_result(res4), .rsp_carry(c4), .rsp_ovf(v4), .rsp_zero(z4)
  );

  addsub_seq_ctrl #(.NIBBLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(tb_vld & sel), .req_ready(rr2),
    .req_a(a[7:0]), .req_b(b[7:0]), .req_mode(m),
    .rsp_valid(rv2), .rsp_ready(tb_rdy & sel),
    .rsp_result(res2), .rsp_carry(c2), .rsp_ovf(v2), .rsp_zero(z2)
  );

  logic        cur_rdy, cur_vld, cur_c, cur_v, cur_z;
  logic [15:0] cur_res;
  assign cur_rdy = sel ? rr2 : rr4;
  assign cur_vld = sel ? rv2 : rv4;
  assign cur_res = sel ? {8'h00, res2} : res4;
  assign cur_c   = sel ? c2 : c4;
  assign cur_v   = sel ? v2 : v4;
  assign cur_z   = sel ? z2 : z4;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [15:0] res;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  // Plain integer arithmetic: unsigned result/carry and signed-range overflow.
  function automatic exp_t model(input logic [15:0] ai, input logic [15:0] bi,
                                 input logic mi, input int w);
    longint md, ua, ub, sa, sb, ru, rs;
    exp_t   e;
    md = longint'(1) << w;
    ua = longint'(ai) % md;
    ub = longint'(bi) % md;
    sa = (ua >= md / 2) ? ua - md : ua;
    sb = (ub >= md / 2) ? ub - md : ub;
    ru = mi ? ua - ub : ua + ub;
    rs = mi ? sa - sb : sa + sb;
    e.res = 16'((ru + md) % md);
    e.c   = mi ? (ua >= ub) : (ru >= md);
    e.v   = (rs >= md / 2) || (rs < -(md / 2));
    e.z   = (e.res == 16'h0);
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!cur_vld && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic do_op(input logic [15:0] ai, input logic [15:0] bi, input logic mi,
                       input string tag, output logic [15:0] o_res, output logic o_c,
                       output logic o_v, output logic o_z);
    int   cyc;
    exp_t e;
    cyc = 0;
    while (!cur_rdy && cyc < 40) begin
      tick();
      cyc++;
    end
    chk({tag, ".req_ready"}, 32'(cur_rdy), 32'd1);
    a = ai; b = bi; m = mi; tb_vld = 1'b1;
    tick();
    tb_vld = 1'b0;
    a = 16'($urandom); b = 16'($urandom); m = 1'($urandom);
    wait_rsp(cyc);
    chk({tag, ".latency"}, 32'(cyc), sel ? 32'd2 : 32'd4);
    e = model(ai, bi, mi, sel ? 8 : 16);
    chk({tag, ".result"}, 32'(cur_res), 32'(e.res));
    chk({tag, ".carry"}, 32'(cur_c), 32'(e.c));
    chk({tag, ".ovf"}, 32'(cur_v), 32'(e.v));
    chk({tag, ".zero"}, 32'(cur_z), 32'(e.z));
    o_res = cur_res; o_c = cur_c; o_v = cur_v; o_z = cur_z;
    tb_rdy = 1'b1;
    tick();
    tb_rdy = 1'b0;
    chk({tag, ".rsp_valid_drop"}, 32'(cur_vld), 32'd0);
  endtask

  logic [15:0] r_res;
  logic        r_c, r_v, r_z;
  int          cyc;
  logic [15:0] ra, rb;

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      4:       return 16'h0080;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; sel = 1'b0; tb_vld = 1'b0; tb_rdy = 1'b0;
    a = '0; b = '0; m = 1'b0;
    #12;
    chk("reset.req_ready", 32'(rr4), 32'd1);
    chk("reset.rsp_valid", 32'(rv4), 32'd0);
    chk("reset.result", 32'(res4), 32'd0);
    chk("reset.flags", {29'd0, c4, v4, z4}, 32'd0);
    chk("reset.req_ready2", 32'(rr2), 32'd1);
    #3 rst_n = 1'b1;
    tick();

    do_op(16'h1234, 16'h0FFF, 1'b0, "add1", r_res, r_c, r_v, r_z);
    chk("add1.lit", {11'd0, r_res, r_c, r_v, r_z}, {11'd0, 16'h2233, 3'b000});
    do_op(16'hFFFF, 16'h0001, 1'b0, "add_ripple", r_res, r_c, r_v, r_z);
    chk("add_ripple.lit", {11'd0, r_res, r_c, r_v, r_z}, {11'd0, 16'h0000, 3'b101});
    do_op(16'h0005, 16'h0007, 1'b1, "sub_borrow", r_res, r_c, r_v, r_z);
    chk("sub_borrow.lit", {11'd0, r_res, r_c, r_v, r_z}, {11'd0, 16'hFFFE, 3'b000});
    do_op(16'h8000, 16'h0001, 1'b1, "sub_ovf", r_res, r_c, r_v, r_z);
    chk("sub_ovf.lit", {11'd0, r_res, r_c, r_v, r_z}, {11'd0, 16'h7FFF, 3'b110});

    // Backpressure with a second request waiting.
    a = 16'h1111; b = 16'h2222; m = 1'b0; tb_vld = 1'b1;
    tick();
    a = 16'h0F0F; b = 16'h0101; m = 1'b1;
    wait_rsp(cyc);
    chk("bp.latency", 32'(cyc), 32'd4);
    for (int k = 0; k < 10; k++) begin
      chk("bp.hold_result", 32'(res4), 32'h3333);
      chk("bp.hold_valid", 32'(rv4), 32'd1);
      chk("bp.req_ready_low", 32'(rr4), 32'd0);
      tick();
    end
    tb_rdy = 1'b1;
    tick();
    tb_rdy = 1'b0;
    chk("bp.idle_ready", 32'(rr4), 32'd1);
    chk("bp.idle_valid", 32'(rv4), 32'd0);
    tick();
    tb_vld = 1'b0;
    chk("bp.second_accepted", 32'(rr4), 32'd0);
    wait_rsp(cyc);
    chk("bp.second_latency", 32'(cyc), 32'd4);
    chk("bp.second_result", 32'(res4), 32'h0E0E);
    chk("bp.second_carry", 32'(c4), 32'd1);
    tb_rdy = 1'b1;
    tick();
    tb_rdy = 1'b0;

    // Asynchronous reset after nibble 1 of an in-flight operation.
    a = 16'hFFFF; b = 16'hFFFF; m = 1'b0; tb_vld = 1'b1;
    tick();
    tb_vld = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.req_ready", 32'(rr4), 32'd1);
    chk("midrst.rsp_valid", 32'(rv4), 32'd0);
    chk("midrst.result", 32'(res4), 32'd0);
    chk("midrst.flags", {29'd0, c4, v4, z4}, 32'd0);
    #3 rst_n = 1'b1;
    do_op(16'h7FFF, 16'h0001, 1'b0, "post_rst", r_res, r_c, r_v, r_z);
    chk("post_rst.lit", {11'd0, r_res, r_c, r_v, r_z}, {11'd0, 16'h8000, 3'b010});

    for (int k = 0; k < 6000; k++) begin
      ra = pick(); rb = pick();
      do_op(ra, rb, 1'($urandom), "rnd16", r_res, r_c, r_v, r_z);
    end

    sel = 1'b1;
    tick();
    do_op(16'h007F, 16'h0001, 1'b0, "n2_ovf", r_res, r_c, r_v, r_z);
    chk("n2_ovf.lit", {11'd0, r_res, r_c, r_v, r_z}, {11'd0, 16'h0080, 3'b010});
    for (int k = 0; k < 2000; k++) begin
      ra = pick(); rb = pick();
      do_op(ra, rb, 1'($urandom), "rnd8", r_res, r_c, r_v, r_z);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
